// File: rtl/perceptron_layer_seq.sv
// -----------------------------------------------------------------------------
// perceptron_layer_seq
//
// Sequential perceptron layer. NUM_NEURONS neurons share one real-valued
// multiply-accumulate step; each neuron has NUM_INPUTS weights. The block runs
// inference and, on request, one in-place gradient-descent step. Both use
// valid/ready handshakes, and the block handles one sample at a time.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        input vector handshake (values, activation, training)
//   out_valid/out_ready      prediction handshake (prediction)
//   grad_valid/grad_ready    upstream gradient handshake (grad_in, learning_rate)
//   back_valid/back_ready    back-gradient handshake (back_gradient)
//   weights_out, bias_out    current layer parameters
//
// Build option
//   PERCEPTRON_RAND_INIT_EN  when defined, reset loads every weight and bias
//                            with a pseudo-random value in [-0.49, 0.5].
//                            When undefined, reset loads INIT_WEIGHT and
//                            INIT_BIAS.
// -----------------------------------------------------------------------------
package perceptron_pkg;
  typedef enum logic [1:0] {
    ACT_SIGMOID = 2'd0,
    ACT_TANH    = 2'd1,
    ACT_RELU    = 2'd2
  } act_func;
endpackage

module perceptron_layer_seq
  import perceptron_pkg::*;
#(
  parameter int  NUM_INPUTS  = 2,
  parameter int  NUM_NEURONS = 2,
  parameter real INIT_WEIGHT = 0.5,
  parameter real INIT_BIAS   = 0.0
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    in_valid,
  output logic    in_ready,
  input  real     values        [NUM_INPUTS],
  input  act_func activation,
  input  logic    training,
  output logic    out_valid,
  input  logic    out_ready,
  output real     prediction    [NUM_NEURONS],
  input  logic    grad_valid,
  output logic    grad_ready,
  input  real     grad_in       [NUM_NEURONS],
  input  real     learning_rate,
  output logic    back_valid,
  input  logic    back_ready,
  output real     back_gradient [NUM_INPUTS],
  output real     weights_out   [NUM_NEURONS][NUM_INPUTS],
  output real     bias_out      [NUM_NEURONS]
);

  localparam int unsigned IW = (NUM_INPUTS  > 1) ? $clog2(NUM_INPUTS)  : 1;
  localparam int unsigned JW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [IW-1:0] LAST_I = IW'(NUM_INPUTS - 1);
  localparam logic [JW-1:0] LAST_J = JW'(NUM_NEURONS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_ACT,
    S_OUT,
    S_WAIT_GRAD,
    S_DELTA,
    S_UPDATE,
    S_BACK
  } state_t;

  state_t  r_state;
  state_t  w_next;

  real     r_w     [NUM_NEURONS][NUM_INPUTS];
  real     r_b     [NUM_NEURONS];
  real     r_x     [NUM_INPUTS];
  real     r_sum   [NUM_NEURONS];
  real     r_pred  [NUM_NEURONS];
  real     r_grad  [NUM_NEURONS];
  real     r_delta [NUM_NEURONS];
  real     r_back  [NUM_INPUTS];
  real     r_lr;
  act_func r_act;
  logic    r_train;

  logic [IW-1:0] r_i;
  logic [JW-1:0] r_j;
  logic          w_last_i;
  logic          w_last;

  assign w_last_i = (r_i == LAST_I);
  assign w_last   = w_last_i && (r_j == LAST_J);

  assign prediction    = r_pred;
  assign back_gradient = r_back;
  assign weights_out   = r_w;
  assign bias_out      = r_b;

  function automatic real f_act(input act_func a, input real s);
    case (a)
      ACT_SIGMOID: return 1.0 / (1.0 + $exp(-s));
      ACT_TANH:    return $tanh(s);
      ACT_RELU:    return (s >= 0.0) ? s : 0.0;
      default:     return 0.0;
    endcase
  endfunction

  // Derivative expressed from the registered prediction p (and the pre-activation
  // sum s for ReLU), so no extra activation evaluation is needed.
  function automatic real f_deriv(input act_func a, input real p, input real s);
    case (a)
      ACT_SIGMOID: return p * (1.0 - p);
      ACT_TANH:    return 1.0 - p * p;
      ACT_RELU:    return (s >= 0.0) ? 1.0 : 0.0;
      default:     return 0.0;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and handshake outputs; every output is forced low while rst is high
  always_comb begin
    w_next     = r_state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    grad_ready = 1'b0;
    back_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_MAC;
      end
      S_MAC:    if (w_last) w_next = S_ACT;
      S_ACT:    w_next = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = r_train ? S_WAIT_GRAD : S_IDLE;
      end
      S_WAIT_GRAD: begin
        grad_ready = 1'b1;
        if (grad_valid) w_next = S_DELTA;
      end
      S_DELTA:  w_next = S_UPDATE;
      S_UPDATE: if (w_last) w_next = S_BACK;
      S_BACK: begin
        back_valid = 1'b1;
        if (back_ready) w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
    if (rst) begin
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      grad_ready = 1'b0;
      back_valid = 1'b0;
    end
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned j = 0; j < NUM_NEURONS; j++) begin
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
`ifdef PERCEPTRON_RAND_INIT_EN
          r_w[j][i] <= $urandom_range(100, 1) / 100.0 - 0.5;
`else
          r_w[j][i] <= INIT_WEIGHT;
`endif
        end
`ifdef PERCEPTRON_RAND_INIT_EN
        r_b[j] <= $urandom_range(100, 1) / 100.0 - 0.5;
`else
        r_b[j] <= INIT_BIAS;
`endif
        r_pred[j] <= 0.0;
      end
      for (int unsigned i = 0; i < NUM_INPUTS; i++) r_back[i] <= 0.0;
      r_i <= '0;
      r_j <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x     <= values;
            r_act   <= activation;
            r_train <= training;
            for (int unsigned j = 0; j < NUM_NEURONS; j++) r_sum[j] <= r_b[j];
            r_i <= '0;
            r_j <= '0;
          end
        end
        S_MAC: begin
          r_sum[r_j] <= r_sum[r_j] + r_w[r_j][r_i] * r_x[r_i];
          if (w_last_i) begin
            r_i <= '0;
            r_j <= w_last ? '0 : r_j + 1'b1;
          end else begin
            r_i <= r_i + 1'b1;
          end
        end
        S_ACT: begin
          for (int unsigned j = 0; j < NUM_NEURONS; j++) r_pred[j] <= f_act(r_act, r_sum[j]);
        end
        S_WAIT_GRAD: begin
          if (grad_valid) begin
            r_grad <= grad_in;
            r_lr   <= learning_rate;
          end
        end
        S_DELTA: begin
          for (int unsigned j = 0; j < NUM_NEURONS; j++)
            r_delta[j] <= r_grad[j] * f_deriv(r_act, r_pred[j], r_sum[j]);
          for (int unsigned i = 0; i < NUM_INPUTS; i++) r_back[i] <= 0.0;
          r_i <= '0;
          r_j <= '0;
        end
        S_UPDATE: begin
          // Each cycle touches a single weight, so the back-gradient term reads
          // the weight before the write scheduled in the same cycle lands.
          r_back[r_i]    <= r_back[r_i] + r_w[r_j][r_i] * r_delta[r_j];
          r_w[r_j][r_i]  <= r_w[r_j][r_i] - r_lr * r_delta[r_j] * r_x[r_i];
          if (w_last_i) r_b[r_j] <= r_b[r_j] - r_lr * r_delta[r_j];
          if (w_last_i) begin
            r_i <= '0;
            r_j <= w_last ? '0 : r_j + 1'b1;
          end else begin
            r_i <= r_i + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_layer_seq.sv
// -----------------------------------------------------------------------------
// tb_perceptron_layer_seq
//
// Self-checking bench for perceptron_layer_seq with default parameters.
// A plain-arithmetic model of the layer (weights, biases, forward pass, one
// gradient step) supplies expected values. Directed tests follow the layer's
// worked examples; a randomized loop covers the remaining behaviour.
// -----------------------------------------------------------------------------
module tb_perceptron_layer_seq;
  import perceptron_pkg::*;

  localparam int NI = 2;
  localparam int NN = 2;
  localparam int LAT = NN * NI + 2;

  typedef real vec_i_t [NI];
  typedef real vec_n_t [NN];

  logic    clk = 1'b0;
  logic    rst;
  logic    in_valid, in_ready, training;
  logic    out_valid, out_ready;
  logic    grad_valid, grad_ready;
  logic    back_valid, back_ready;
  real     values        [NI];
  act_func activation;
  real     prediction    [NN];
  real     grad_in       [NN];
  real     learning_rate;
  real     back_gradient [NI];
  real     weights_out   [NN][NI];
  real     bias_out      [NN];

  int errors = 0;
  int checks = 0;

  real m_w    [NN][NI];
  real m_b    [NN];
  real m_sum  [NN];
  real m_pred [NN];
  real m_back [NI];

  always #5 clk = ~clk;

  perceptron_layer_seq #(
    .NUM_INPUTS (NI),
    .NUM_NEURONS(NN),
    .INIT_WEIGHT(0.5),
    .INIT_BIAS  (0.0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .values       (values),
    .activation   (activation),
    .training     (training),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .prediction   (prediction),
    .grad_valid   (grad_valid),
    .grad_ready   (grad_ready),
    .grad_in      (grad_in),
    .learning_rate(learning_rate),
    .back_valid   (back_valid),
    .back_ready   (back_ready),
    .back_gradient(back_gradient),
    .weights_out  (weights_out),
    .bias_out     (bias_out)
  );

  function automatic bit near(input real a, input real b);
    return ((a - b) < 1e-9) && ((b - a) < 1e-9);
  endfunction

  // ---------------- reference model ----------------
  function automatic real ref_act(input act_func a, input real s);
    if (a == ACT_SIGMOID) return 1.0 / (1.0 + $exp(-s));
    if (a == ACT_TANH)    return $tanh(s);
    if (a == ACT_RELU)    return (s < 0.0) ? 0.0 : s;
    return 0.0;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < NN; j++) begin
      for (int i = 0; i < NI; i++) m_w[j][i] = 0.5;
      m_b[j] = 0.0;
      m_pred[j] = 0.0;
    end
    for (int i = 0; i < NI; i++) m_back[i] = 0.0;
  endtask

  task automatic model_infer(input vec_i_t x, input act_func a);
    for (int j = 0; j < NN; j++) begin
      m_sum[j] = m_b[j];
      for (int i = 0; i < NI; i++) m_sum[j] = m_sum[j] + m_w[j][i] * x[i];
      m_pred[j] = ref_act(a, m_sum[j]);
    end
  endtask

  task automatic model_train(input vec_i_t x, input act_func a, input vec_n_t g, input real lr);
    real delta [NN];
    real d;
    for (int j = 0; j < NN; j++) begin
      if (a == ACT_SIGMOID)   d = m_pred[j] * (1.0 - m_pred[j]);
      else if (a == ACT_TANH) d = 1.0 - m_pred[j] * m_pred[j];
      else if (a == ACT_RELU) d = (m_sum[j] >= 0.0) ? 1.0 : 0.0;
      else                    d = 0.0;
      delta[j] = g[j] * d;
    end
    for (int i = 0; i < NI; i++) begin
      m_back[i] = 0.0;
      for (int j = 0; j < NN; j++) m_back[i] = m_back[i] + m_w[j][i] * delta[j];
    end
    for (int j = 0; j < NN; j++) begin
      for (int i = 0; i < NI; i++) m_w[j][i] = m_w[j][i] - lr * delta[j] * x[i];
      m_b[j] = m_b[j] - lr * delta[j];
    end
  endtask

  // ---------------- drivers (no checking) ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_input(input vec_i_t x, input act_func a, input logic t);
    @(negedge clk);
    values     = x;
    activation = a;
    training   = t;
    in_valid   = 1'b1;
    for (int n = 0; n < 50 && !in_ready; n++) @(negedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // k+1 is the edge (counted from the handshake edge 0) where valid is first seen
  task automatic wait_out(output int k);
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 200) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
  endtask

  task automatic send_grad(input vec_n_t g, input real lr);
    @(negedge clk);
    grad_in       = g;
    learning_rate = lr;
    grad_valid    = 1'b1;
    for (int n = 0; n < 50 && !grad_ready; n++) @(negedge clk);
    @(posedge clk);
    #1 grad_valid = 1'b0;
  endtask

  task automatic wait_back(output int k);
    k = 0;
    @(negedge clk);
    while (!back_valid && k < 200) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
  endtask

  task automatic finish_handshake();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (grad_ready !== 1'b0) begin errors++; $display("FAIL rst_grad_ready: got %b want 0", grad_ready); end
    checks++; if (back_valid !== 1'b0) begin errors++; $display("FAIL rst_back_valid: got %b want 0", back_valid); end
    for (int j = 0; j < NN; j++) begin
      checks++; if (!near(prediction[j], 0.0)) begin errors++; $display("FAIL rst_pred[%0d]: got %f want 0.0", j, prediction[j]); end
      checks++; if (!near(bias_out[j], 0.0))   begin errors++; $display("FAIL rst_bias[%0d]: got %f want 0.0", j, bias_out[j]); end
      for (int i = 0; i < NI; i++) begin
        checks++; if (!near(weights_out[j][i], 0.5)) begin errors++; $display("FAIL rst_w[%0d][%0d]: got %f want 0.5", j, i, weights_out[j][i]); end
      end
    end
    for (int i = 0; i < NI; i++) begin
      checks++; if (!near(back_gradient[i], 0.0)) begin errors++; $display("FAIL rst_back[%0d]: got %f want 0.0", i, back_gradient[i]); end
    end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready: got %b want 1", in_ready); end
    model_reset();
  endtask

  task automatic test_infer_relu();
    vec_i_t x = '{1.0, 2.0};
    int k;
    out_ready = 1'b1;
    send_input(x, ACT_RELU, 1'b0);
    model_infer(x, ACT_RELU);
    wait_out(k);
    checks++; if (k + 1 != LAT) begin errors++; $display("FAIL infer_latency: got edge %0d want %0d", k + 1, LAT); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL infer_busy_in_ready: got %b want 0", in_ready); end
    for (int j = 0; j < NN; j++) begin
      checks++; if (!near(prediction[j], 1.5)) begin errors++; $display("FAIL infer_pred[%0d]: got %f want 1.5", j, prediction[j]); end
    end
    finish_handshake();
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL infer_idle: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_train_relu();
    vec_i_t x = '{1.0, 2.0};
    vec_n_t g = '{1.0, 1.0};
    vec_i_t wexp = '{0.4, 0.3};
    int k;
    out_ready = 1'b1;
    back_ready = 1'b1;
    send_input(x, ACT_RELU, 1'b1);
    model_infer(x, ACT_RELU);
    wait_out(k);
    checks++; if (!near(prediction[0], 1.5)) begin errors++; $display("FAIL train_pred: got %f want 1.5", prediction[0]); end
    finish_handshake();
    send_grad(g, 0.1);
    model_train(x, ACT_RELU, g, 0.1);
    wait_back(k);
    checks++; if (k + 1 != LAT) begin errors++; $display("FAIL train_latency: got edge %0d want %0d", k + 1, LAT); end
    for (int i = 0; i < NI; i++) begin
      checks++; if (!near(back_gradient[i], 1.0)) begin errors++; $display("FAIL train_back[%0d]: got %f want 1.0", i, back_gradient[i]); end
    end
    finish_handshake();
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL train_idle: got in_ready=%b want 1", in_ready); end
    for (int j = 0; j < NN; j++) begin
      checks++; if (!near(bias_out[j], -0.1)) begin errors++; $display("FAIL train_bias[%0d]: got %f want -0.1", j, bias_out[j]); end
      for (int i = 0; i < NI; i++) begin
        checks++; if (!near(weights_out[j][i], wexp[i])) begin errors++; $display("FAIL train_w[%0d][%0d]: got %f want %f", j, i, weights_out[j][i], wexp[i]); end
      end
    end
  endtask

  task automatic test_reinfer();
    vec_i_t x = '{1.0, 2.0};
    int k;
    send_input(x, ACT_RELU, 1'b0);
    model_infer(x, ACT_RELU);
    wait_out(k);
    for (int j = 0; j < NN; j++) begin
      checks++; if (!near(prediction[j], 0.9)) begin errors++; $display("FAIL reinfer_pred[%0d]: got %f want 0.9", j, prediction[j]); end
    end
    finish_handshake();
  endtask

  task automatic test_sigmoid_train();
    vec_i_t x = '{0.0, 0.0};
    vec_n_t g = '{1.0, 0.0};
    vec_n_t bexp = '{-0.25, 0.0};
    int k;
    apply_reset();
    rst = 1'b0;
    model_reset();
    send_input(x, ACT_SIGMOID, 1'b1);
    model_infer(x, ACT_SIGMOID);
    wait_out(k);
    for (int j = 0; j < NN; j++) begin
      checks++; if (!near(prediction[j], 0.5)) begin errors++; $display("FAIL sig_pred[%0d]: got %f want 0.5", j, prediction[j]); end
    end
    finish_handshake();
    send_grad(g, 1.0);
    model_train(x, ACT_SIGMOID, g, 1.0);
    wait_back(k);
    for (int i = 0; i < NI; i++) begin
      checks++; if (!near(back_gradient[i], 0.125)) begin errors++; $display("FAIL sig_back[%0d]: got %f want 0.125", i, back_gradient[i]); end
    end
    finish_handshake();
    @(negedge clk);
    for (int j = 0; j < NN; j++) begin
      checks++; if (!near(bias_out[j], bexp[j])) begin errors++; $display("FAIL sig_bias[%0d]: got %f want %f", j, bias_out[j], bexp[j]); end
      for (int i = 0; i < NI; i++) begin
        checks++; if (!near(weights_out[j][i], 0.5)) begin errors++; $display("FAIL sig_w[%0d][%0d]: got %f want 0.5", j, i, weights_out[j][i]); end
      end
    end
  endtask

  task automatic test_other_act();
    vec_i_t x = '{0.75, -1.25};
    vec_n_t g = '{1.0, -2.0};
    act_func a = act_func'(2'd3);
    int k;
    send_input(x, a, 1'b1);
    model_infer(x, a);
    wait_out(k);
    for (int j = 0; j < NN; j++) begin
      checks++; if (!near(prediction[j], 0.0)) begin errors++; $display("FAIL other_pred[%0d]: got %f want 0.0", j, prediction[j]); end
    end
    finish_handshake();
    send_grad(g, 0.5);
    model_train(x, a, g, 0.5);
    wait_back(k);
    for (int i = 0; i < NI; i++) begin
      checks++; if (!near(back_gradient[i], 0.0)) begin errors++; $display("FAIL other_back[%0d]: got %f want 0.0", i, back_gradient[i]); end
    end
    finish_handshake();
    @(negedge clk);
    for (int j = 0; j < NN; j++) begin
      checks++; if (!near(bias_out[j], m_b[j])) begin errors++; $display("FAIL other_bias[%0d]: got %f want %f", j, bias_out[j], m_b[j]); end
    end
  endtask

  task automatic test_backpressure();
    vec_i_t x = '{1.5, -0.5};
    vec_n_t g = '{0.5, -1.0};
    real held [NN];
    real bheld [NI];
    int k;
    out_ready = 1'b0;
    send_input(x, ACT_TANH, 1'b1);
    model_infer(x, ACT_TANH);
    wait_out(k);
    held = prediction;
    for (int j = 0; j < NN; j++) begin
      checks++; if (!near(prediction[j], m_pred[j])) begin errors++; $display("FAIL bp_pred[%0d]: got %f want %f", j, prediction[j], m_pred[j]); end
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || prediction[0] != held[0] || prediction[1] != held[1]) begin
        errors++;
        $display("FAIL bp_out_hold: cycle %0d got out_valid=%b in_ready=%b pred=%f,%f want 1/0 pred=%f,%f",
                 c, out_valid, in_ready, prediction[0], prediction[1], held[0], held[1]);
      end
    end
    out_ready = 1'b1;
    finish_handshake();
    back_ready = 1'b0;
    send_grad(g, 0.05);
    model_train(x, ACT_TANH, g, 0.05);
    wait_back(k);
    bheld = back_gradient;
    for (int i = 0; i < NI; i++) begin
      checks++; if (!near(back_gradient[i], m_back[i])) begin errors++; $display("FAIL bp_back[%0d]: got %f want %f", i, back_gradient[i], m_back[i]); end
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (back_valid !== 1'b1 || back_gradient[0] != bheld[0] || back_gradient[1] != bheld[1]) begin
        errors++;
        $display("FAIL bp_back_hold: cycle %0d got back_valid=%b back=%f,%f want 1 back=%f,%f",
                 c, back_valid, back_gradient[0], back_gradient[1], bheld[0], bheld[1]);
      end
    end
    back_ready = 1'b1;
    finish_handshake();
  endtask

  task automatic test_random();
    vec_i_t x;
    vec_n_t g;
    act_func a;
    logic t;
    int k;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NI; i++) x[i] = real'($urandom_range(400, 0)) / 100.0 - 2.0;
      for (int j = 0; j < NN; j++) g[j] = real'($urandom_range(200, 0)) / 100.0 - 1.0;
      a = act_func'(2'($urandom_range(2, 0)));
      t = 1'($urandom_range(1, 0));
      send_input(x, a, t);
      model_infer(x, a);
      wait_out(k);
      checks++; if (k + 1 != LAT) begin errors++; $display("FAIL rnd_latency: iter %0d got edge %0d want %0d", n, k + 1, LAT); end
      for (int j = 0; j < NN; j++) begin
        checks++; if (!near(prediction[j], m_pred[j])) begin errors++; $display("FAIL rnd_pred[%0d]: iter %0d got %f want %f", j, n, prediction[j], m_pred[j]); end
      end
      finish_handshake();
      if (t) begin
        send_grad(g, 0.1);
        model_train(x, a, g, 0.1);
        wait_back(k);
        checks++; if (k + 1 != LAT) begin errors++; $display("FAIL rnd_back_latency: iter %0d got edge %0d want %0d", n, k + 1, LAT); end
        for (int i = 0; i < NI; i++) begin
          checks++; if (!near(back_gradient[i], m_back[i])) begin errors++; $display("FAIL rnd_back[%0d]: iter %0d got %f want %f", i, n, back_gradient[i], m_back[i]); end
        end
        finish_handshake();
      end
      @(negedge clk);
      for (int j = 0; j < NN; j++) begin
        checks++; if (!near(bias_out[j], m_b[j])) begin errors++; $display("FAIL rnd_bias[%0d]: iter %0d got %f want %f", j, n, bias_out[j], m_b[j]); end
        for (int i = 0; i < NI; i++) begin
          checks++; if (!near(weights_out[j][i], m_w[j][i])) begin errors++; $display("FAIL rnd_w[%0d][%0d]: iter %0d got %f want %f", j, i, n, weights_out[j][i], m_w[j][i]); end
        end
      end
    end
  endtask

  task automatic test_reset_mid_update();
    vec_i_t x = '{1.0, 2.0};
    vec_n_t g = '{1.0, 1.0};
    int k;
    apply_reset();
    rst = 1'b0;
    model_reset();
    send_input(x, ACT_RELU, 1'b1);
    wait_out(k);
    finish_handshake();
    send_grad(g, 0.1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++; if (!near(weights_out[0][0], 0.4)) begin errors++; $display("FAIL mid_partial_w: got %f want 0.4", weights_out[0][0]); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || back_valid !== 1'b0 || in_ready !== 1'b0)
      begin errors++; $display("FAIL mid_rst_hs: got out_valid=%b back_valid=%b in_ready=%b want 0/0/0", out_valid, back_valid, in_ready); end
    for (int j = 0; j < NN; j++) begin
      checks++; if (!near(bias_out[j], 0.0)) begin errors++; $display("FAIL mid_rst_bias[%0d]: got %f want 0.0", j, bias_out[j]); end
      for (int i = 0; i < NI; i++) begin
        checks++; if (!near(weights_out[j][i], 0.5)) begin errors++; $display("FAIL mid_rst_w[%0d][%0d]: got %f want 0.5", j, i, weights_out[j][i]); end
      end
    end
    for (int i = 0; i < NI; i++) begin
      checks++; if (!near(back_gradient[i], 0.0)) begin errors++; $display("FAIL mid_rst_back[%0d]: got %f want 0.0", i, back_gradient[i]); end
    end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_idle: got in_ready=%b want 1", in_ready); end
    send_input(x, ACT_RELU, 1'b0);
    wait_out(k);
    checks++; if (!near(prediction[1], 1.5)) begin errors++; $display("FAIL mid_rst_reinfer: got %f want 1.5", prediction[1]); end
    finish_handshake();
  endtask

  initial begin
    rst           = 1'b1;
    in_valid      = 1'b0;
    training      = 1'b0;
    out_ready     = 1'b1;
    grad_valid    = 1'b0;
    back_ready    = 1'b1;
    activation    = ACT_RELU;
    learning_rate = 0.0;
    for (int i = 0; i < NI; i++) values[i] = 0.0;
    for (int j = 0; j < NN; j++) grad_in[j] = 0.0;

    test_reset();
    test_infer_relu();
    test_train_relu();
    test_reinfer();
    test_sigmoid_train();
    test_other_act();
    test_backpressure();
    test_random();
    test_reset_mid_update();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
